// File: rtl/pico_arb_defs.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_arb_defs : state encodings and defaults shared by the arbiter files
// Rev 1.0
// ---------------------------------------------------------------------------
package pico_arb_defs;

  localparam int          MAX_REQ               = 4;
  localparam logic [31:0] DEFAULT_TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_t;

  // (base + offset) mod num, for base < num and offset <= num
  function automatic int rr_index(input int base, input int offset, input int num);
    int idx;
    idx = base + offset;
    if (idx >= num) idx = idx - num;
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pico_mem_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_mem_arbiter_if : requester-side and downstream native memory bus
// Rev 1.0
// ---------------------------------------------------------------------------
interface pico_mem_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   s_valid;
  logic [NUM_REQ-1:0]   s_instr;
  logic [32*NUM_REQ-1:0] s_addr;
  logic [32*NUM_REQ-1:0] s_wdata;
  logic [4*NUM_REQ-1:0] s_wstrb;
  logic [NUM_REQ-1:0]   s_ready;
  logic [31:0]          s_rdata;
  logic                 m_valid;
  logic                 m_instr;
  logic [31:0]          m_addr;
  logic [31:0]          m_wdata;
  logic [3:0]           m_wstrb;
  logic                 m_ready;
  logic [31:0]          m_rdata;

  // slave is the arbiter itself; master is everything around it
  modport slave (
    input  s_valid, s_instr, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
    output s_ready, s_rdata, m_valid, m_instr, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output s_valid, s_instr, s_addr, s_wdata, s_wstrb, m_ready, m_rdata,
    input  s_ready, s_rdata, m_valid, m_instr, m_addr, m_wdata, m_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/pico_rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_rr_pick : first set request bit searching upward from last grant + 1
// Rev 1.0
// ---------------------------------------------------------------------------
module pico_rr_pick
  import pico_arb_defs::*;
#(
  parameter int NUM_REQ = 2
) (
  input  wire  [NUM_REQ-1:0] req,
  input  wire  [1:0]         last,
  output logic [1:0]         next,
  output logic               any_req
);

  // Walk offsets from farthest to nearest so the nearest hit is written last
  always_comb begin
    next    = last;
    any_req = |req;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (req[rr_index(int'(last), off, NUM_REQ)]) begin
        next = 2'(rr_index(int'(last), off, NUM_REQ));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pico_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pico_mem_arbiter : round-robin share of one PicoRV32 native port, with watchdog
// Rev 1.0
// ---------------------------------------------------------------------------
module pico_mem_arbiter
  import pico_arb_defs::*;
#(
  parameter int          NUM_REQ        = 2,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] TIMEOUT_RDATA  = DEFAULT_TIMEOUT_RDATA
) (
  input  wire               HCLK,
  input  wire               HRESET,
  pico_mem_arbiter_if.slave bus,
  output logic [1:0]        grant_id,
  output logic              busy,
  output logic              timeout_pulse
);

  localparam int                 c_cnt_w     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic               c_wd_en     = (TIMEOUT_CYCLES != 0);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic [1:0]         c_grant_rst = 2'(NUM_REQ - 1);

  arb_state_t         state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic               m_valid_q, m_valid_d;
  logic               m_instr_q, m_instr_d;
  logic [31:0]        m_addr_q, m_addr_d;
  logic [31:0]        m_wdata_q, m_wdata_d;
  logic [3:0]         m_wstrb_q, m_wstrb_d;

  logic [31:0]        w_addr  [NUM_REQ];
  logic [31:0]        w_wdata [NUM_REQ];
  logic [3:0]         w_wstrb [NUM_REQ];
  logic [1:0]         w_pick;
  logic               w_any_req;
  logic               w_timeout_hit;
  logic               w_fire;
  logic [NUM_REQ-1:0] w_ready;

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
      assign w_addr[g]  = bus.s_addr[32*g +: 32];
      assign w_wdata[g] = bus.s_wdata[32*g +: 32];
      assign w_wstrb[g] = bus.s_wstrb[4*g +: 4];
    end
  endgenerate

  pico_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req     (bus.s_valid),
    .last    (grant_q),
    .next    (w_pick),
    .any_req (w_any_req)
  );

  // A real completion in the final watchdog cycle takes precedence over the timeout
  assign w_timeout_hit = c_wd_en & (state_q == ST_BUSY) & (cnt_q == c_cnt_last) & ~bus.m_ready;
  assign w_fire        = (state_q == ST_BUSY) & (bus.m_ready | w_timeout_hit);

  always_comb begin
    w_ready = '0;
    if (w_fire) w_ready[grant_q] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    unique case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          grant_d   = w_pick;
          m_valid_d = 1'b1;
          m_instr_d = bus.s_instr[w_pick];
          m_addr_d  = w_addr[w_pick];
          m_wdata_d = w_wdata[w_pick];
          m_wstrb_d = w_wstrb[w_pick];
          cnt_d     = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + c_cnt_one;
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end else if (w_timeout_hit) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The downstream beat still completes; its data has no consumer
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      grant_q   <= c_grant_rst;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_instr_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

  assign bus.s_ready   = w_ready;
  assign bus.s_rdata   = bus.m_ready ? bus.m_rdata : TIMEOUT_RDATA;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_instr   = m_instr_q;
  assign bus.m_addr    = m_addr_q;
  assign bus.m_wdata   = m_wdata_q;
  assign bus.m_wstrb   = m_wstrb_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_pulse = w_timeout_hit;

endmodule
`default_nettype wire

// File: tb/tb_pico_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pico_mem_arbiter : directed scenarios plus randomized traffic vs a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_pico_mem_arbiter;
  import pico_arb_defs::*;

  localparam int          N       = 2;
  localparam int          TO      = 8;
  localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_pulse;
  int         checks   = 0;
  int         failures = 0;

  pico_mem_arbiter_if #(.NUM_REQ(N)) bus ();

  pico_mem_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_RDATA  (TO_DATA)
  ) dut (
    .HCLK          (clk),
    .HRESET        (rst),
    .bus           (bus),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  logic [3:0] pk_req;
  logic [1:0] pk_last;
  logic [1:0] pk_next;
  logic       pk_any;

  pico_rr_pick #(.NUM_REQ(4)) u_pick (
    .req     (pk_req),
    .last    (pk_last),
    .next    (pk_next),
    .any_req (pk_any)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic clear_inputs();
    bus.s_valid = '0;
    bus.s_instr = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    bus.s_wstrb = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
  endtask

  task automatic set_req(input int i, input logic v, input logic ins,
                         input logic [31:0] a, input logic [31:0] w, input logic [3:0] st);
    bus.s_valid[i]         = v;
    bus.s_instr[i]         = ins;
    bus.s_addr[32*i +: 32] = a;
    bus.s_wdata[32*i +: 32] = w;
    bus.s_wstrb[4*i +: 4]  = st;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_rr_pick();
    logic [3:0] r;
    int         exp;
    bit         found;
    for (int req = 0; req < 16; req++) begin
      for (int last = 0; last < 4; last++) begin
        r       = 4'(req);
        pk_req  = r;
        pk_last = 2'(last);
        #1;
        exp   = last;
        found = 1'b0;
        for (int off = 1; off <= 4; off++) begin
          if (!found && r[(last + off) % 4]) begin
            exp   = (last + off) % 4;
            found = 1'b1;
          end
        end
        checks++;
        if (pk_any !== (r != 4'd0) || (found && pk_next !== 2'(exp))) begin
          failures++;
          $display("FAIL rr_pick req=%b last=%0d got next=%0d any=%b exp next=%0d any=%b",
                   r, last, pk_next, pk_any, exp, found);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({bus.m_valid, bus.m_instr, bus.m_wstrb, bus.s_ready, busy, timeout_pulse} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl m_valid=%b m_instr=%b m_wstrb=%h s_ready=%b busy=%b pulse=%b exp all 0",
               bus.m_valid, bus.m_instr, bus.m_wstrb, bus.s_ready, busy, timeout_pulse);
    end
    checks++;
    if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data m_addr=%h m_wdata=%h exp 0", bus.m_addr, bus.m_wdata);
    end
    checks++;
    if (grant_id !== 2'(N - 1)) begin
      failures++;
      $display("FAIL reset_grant got=%0d exp=%0d", grant_id, N - 1);
    end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h4000_0000, 32'h0, 4'h0);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early m_valid=%b exp 0", bus.m_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b1 || bus.m_addr !== 32'h4000_0000 || grant_id !== 2'd0 || bus.s_ready !== 2'b00) begin
      failures++;
      $display("FAIL single_grant m_valid=%b m_addr=%h grant=%0d s_ready=%b exp 1 40000000 0 00",
               bus.m_valid, bus.m_addr, grant_id, bus.s_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b1 || bus.s_ready !== 2'b00) begin
      failures++;
      $display("FAIL single_wait m_valid=%b s_ready=%b exp 1 00", bus.m_valid, bus.s_ready);
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0000_0013;
    #1;
    checks++;
    if (bus.s_ready !== 2'b01 || bus.s_rdata !== 32'h0000_0013) begin
      failures++;
      $display("FAIL single_ready s_ready=%b s_rdata=%h exp 01 00000013", bus.s_ready, bus.s_rdata);
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    bus.s_valid = '0;
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_done m_valid=%b s_ready=%b busy=%b exp 0 00 0", bus.m_valid, bus.s_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_no_regrant m_valid=%b exp 0", bus.m_valid);
    end
  endtask

  task automatic test_fairness();
    int got[$];
    int cyc;
    int last;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 32'h2000_0000, 32'h0, 4'h0);
    cyc = 0;
    while (got.size() < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      bus.m_ready = bus.m_valid;
      bus.m_rdata = $urandom;
      #1;
      checks++;
      if (bus.s_ready === 2'b11) begin
        failures++;
        $display("FAIL fair_both_ready cycle=%0d s_ready=%b", cyc, bus.s_ready);
      end
      if (bus.s_ready != 2'b00) got.push_back(bus.s_ready[1] ? 1 : 0);
    end
    clear_inputs();
    checks++;
    if (got.size() < 6) begin
      failures++;
      $display("FAIL fair_bound got %0d grants exp 6", got.size());
    end
    last = N - 1;
    for (int k = 0; k < got.size(); k++) begin
      last = (last + 1) % N;
      checks++;
      if (got[k] !== last) begin
        failures++;
        $display("FAIL fair_order idx=%0d got=%0d exp=%0d", k, got[k], last);
      end
    end
  endtask

  task automatic test_write();
    do_reset();
    set_req(0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h1111_1111, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h8000_0100, 32'hA5A5_5A5A, 4'b0011);
    @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if ({bus.m_valid, bus.m_instr, bus.m_addr, bus.m_wdata, bus.m_wstrb} !==
          {1'b1, 1'b0, 32'h8000_0100, 32'hA5A5_5A5A, 4'b0011} || grant_id !== 2'd1 || bus.s_ready !== 2'b00) begin
        failures++;
        $display("FAIL write_hold cycle=%0d valid=%b instr=%b addr=%h wdata=%h wstrb=%b grant=%0d",
                 c, bus.m_valid, bus.m_instr, bus.m_addr, bus.m_wdata, bus.m_wstrb, grant_id);
      end
      // Inputs changing after grant must not reach the held downstream request
      bus.s_addr[63:32] = 32'h0;
      bus.s_wstrb[7:4]  = 4'hF;
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 2'b10) begin
      failures++;
      $display("FAIL write_ready s_ready=%b exp 10", bus.s_ready);
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++;
      $display("FAIL write_done m_valid=%b exp 0", bus.m_valid);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    set_req(1, 1'b1, 1'b1, 32'h0000_0200, 32'h0, 4'h0);
    @(posedge clk);
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (bus.s_ready !== ((c == TO) ? 2'b01 : 2'b00) || timeout_pulse !== (c == TO) ||
          bus.m_valid !== 1'b1 || grant_id !== 2'd0) begin
        failures++;
        $display("FAIL timeout_wait cycle=%0d s_ready=%b pulse=%b m_valid=%b grant=%0d",
                 c, bus.s_ready, timeout_pulse, bus.m_valid, grant_id);
      end
    end
    checks++;
    if (bus.s_rdata !== TO_DATA) begin
      failures++;
      $display("FAIL timeout_rdata got=%h exp=%h", bus.s_rdata, TO_DATA);
    end
    for (int d = 0; d < 3; d++) begin
      @(negedge clk);
      if (d == 0) bus.s_valid[0] = 1'b0;
      #1;
      checks++;
      if (bus.m_valid !== 1'b1 || busy !== 1'b1 || bus.s_ready !== 2'b00 || timeout_pulse !== 1'b0 ||
          bus.m_addr !== 32'h0000_0100) begin
        failures++;
        $display("FAIL timeout_drain d=%0d m_valid=%b busy=%b s_ready=%b pulse=%b m_addr=%h",
                 d, bus.m_valid, busy, bus.s_ready, timeout_pulse, bus.m_addr);
      end
    end
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0000_1234;
    #1;
    checks++;
    if (bus.s_ready !== 2'b00) begin
      failures++;
      $display("FAIL timeout_drain_ready s_ready=%b exp 00", bus.s_ready);
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_idle m_valid=%b busy=%b exp 0 0", bus.m_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || grant_id !== 2'd1 || bus.m_addr !== 32'h0000_0200 || bus.m_instr !== 1'b1) begin
      failures++;
      $display("FAIL timeout_next m_valid=%b grant=%0d m_addr=%h m_instr=%b exp 1 1 00000200 1",
               bus.m_valid, grant_id, bus.m_addr, bus.m_instr);
    end
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0000_0077;
    #1;
    checks++;
    if (bus.s_ready !== 2'b10 || bus.s_rdata !== 32'h0000_0077) begin
      failures++;
      $display("FAIL timeout_next_ready s_ready=%b s_rdata=%h exp 10 00000077", bus.s_ready, bus.s_rdata);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout_race();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    @(posedge clk);
    repeat (TO - 1) @(negedge clk);
    @(negedge clk);
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h55AA_0FF0;
    #1;
    checks++;
    if (bus.s_ready !== 2'b01 || bus.s_rdata !== 32'h55AA_0FF0 || timeout_pulse !== 1'b0) begin
      failures++;
      $display("FAIL race_ready s_ready=%b s_rdata=%h pulse=%b exp 01 55aa0ff0 0",
               bus.s_ready, bus.s_rdata, timeout_pulse);
    end
    @(negedge clk);
    clear_inputs();
    checks++;
    if (bus.m_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL race_no_drain m_valid=%b busy=%b exp 0 0", bus.m_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'hC000_0000, 32'h0000_0001, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'hC000_0004, 32'h0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_id !== 2'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre grant=%0d busy=%b exp 0 1", grant_id, busy);
    end
    rst         = 1'b1;
    bus.m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.m_valid !== 1'b0 || bus.s_ready !== 2'b00 || busy !== 1'b0 || grant_id !== 2'(N - 1) ||
        bus.m_addr !== 32'h0 || bus.m_wstrb !== 4'h0) begin
      failures++;
      $display("FAIL rstmid_state m_valid=%b s_ready=%b busy=%b grant=%0d m_addr=%h m_wstrb=%h",
               bus.m_valid, bus.s_ready, busy, grant_id, bus.m_addr, bus.m_wstrb);
    end
    rst         = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b1 || grant_id !== 2'd0 || bus.m_addr !== 32'hC000_0000) begin
      failures++;
      $display("FAIL rstmid_regrant m_valid=%b grant=%0d m_addr=%h exp 1 0 c0000000",
               bus.m_valid, grant_id, bus.m_addr);
    end
    clear_inputs();
  endtask

  task automatic test_random();
    bit          act, rel, hit, found;
    int          owner, last, age, delay, idx;
    logic        ins;
    logic [31:0] adr, wd, rd;
    logic [3:0]  st;
    bit          pend [N];
    bit          done [N];
    logic [N-1:0] exp_ready;
    do_reset();
    act   = 1'b0;
    rel   = 1'b0;
    last  = N - 1;
    owner = 0;
    age   = 0;
    delay = 0;
    ins   = 1'b0;
    adr   = '0;
    wd    = '0;
    st    = '0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      done[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      checks++;
      if (bus.m_valid !== act || busy !== act || grant_id !== 2'(last)) begin
        failures++;
        $display("FAIL rand_state cycle=%0d m_valid=%b busy=%b grant=%0d exp %b %b %0d",
                 cyc, bus.m_valid, busy, grant_id, act, act, last);
      end
      if (act) begin
        checks++;
        if ({bus.m_instr, bus.m_addr, bus.m_wdata, bus.m_wstrb} !== {ins, adr, wd, st}) begin
          failures++;
          $display("FAIL rand_fields cycle=%0d got %b %h %h %h exp %b %h %h %h", cyc,
                   bus.m_instr, bus.m_addr, bus.m_wdata, bus.m_wstrb, ins, adr, wd, st);
        end
      end
      for (int i = 0; i < N; i++) begin
        if (done[i]) begin
          done[i] = 1'b0;
          pend[i] = 1'b0;
          bus.s_valid[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          set_req(i, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
        end else if (pend[i] && !(act && owner == i) && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
          bus.s_valid[i] = 1'b0;
        end
      end
      rd = $urandom;
      bus.m_rdata = rd;
      if (act && delay == 0) begin
        bus.m_ready = 1'b1;
      end else begin
        bus.m_ready = 1'b0;
        if (act) delay--;
      end
      #1;
      hit       = act && !rel && !bus.m_ready && (age == TO - 1);
      exp_ready = '0;
      if (act && !rel && (bus.m_ready || hit)) exp_ready[owner] = 1'b1;
      checks++;
      if (bus.s_ready !== exp_ready || timeout_pulse !== hit) begin
        failures++;
        $display("FAIL rand_ready cycle=%0d s_ready=%b pulse=%b exp %b %b",
                 cyc, bus.s_ready, timeout_pulse, exp_ready, hit);
      end
      if (exp_ready != '0) begin
        checks++;
        if (bus.s_rdata !== (bus.m_ready ? rd : TO_DATA)) begin
          failures++;
          $display("FAIL rand_rdata cycle=%0d got=%h exp=%h", cyc, bus.s_rdata, bus.m_ready ? rd : TO_DATA);
        end
        done[owner] = 1'b1;
      end
      if (act) begin
        if (bus.m_ready) begin
          act = 1'b0;
        end else begin
          if (hit) begin
            rel   = 1'b1;
            delay = $urandom_range(0, 3);
          end
          age++;
        end
      end else begin
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
          idx = (last + off) % N;
          if (!found && bus.s_valid[idx]) begin
            found = 1'b1;
            act   = 1'b1;
            rel   = 1'b0;
            age   = 0;
            owner = idx;
            last  = idx;
            ins   = bus.s_instr[idx];
            adr   = bus.s_addr[32*idx +: 32];
            wd    = bus.s_wdata[32*idx +: 32];
            st    = bus.s_wstrb[4*idx +: 4];
            delay = $urandom_range(0, 10);
          end
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_rr_pick();
    test_reset();
    test_single();
    test_fairness();
    test_write();
    test_timeout();
    test_timeout_race();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
